// File: rtl/rv0_trap_ctrl_pkg.sv
// Shared rv0 core definitions for the trap controller: CSR addresses, FSM
// states, machine interrupt codes and mstatus bit positions.
package rv0_trap_ctrl_pkg;

  // Machine-mode CSR addresses touched by trap entry and mret
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Machine interrupt exception codes
  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_MEPC    = 3'd1,
    WR_MCAUSE  = 3'd2,
    WR_MTVAL   = 3'd3,
    WR_MSTATUS = 3'd4,
    REDIRECT   = 3'd5
  } trap_state_e;

endpackage

// File: rtl/rv0_trap_ctrl_irq_prio.sv
// Machine interrupt priority encoder: picks MEI > MSI > MTI from the already
// masked pending lines {MEIP,MTIP,MSIP} and forms the interrupt mcause value.
module rv0_irq_prio
  import rv0_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      irq_i,
  output logic            valid_o,
  output logic [3:0]      code_o,
  output logic [XLEN-1:0] cause_o
);

  // Fixed-priority selection and cause formation with the interrupt flag in the MSB
  always_comb begin
    valid_o = |irq_i;
    code_o  = '0;
    cause_o = '0;
    if (irq_i[2]) begin
      code_o = IRQ_CODE_MEI;
    end else if (irq_i[0]) begin
      code_o = IRQ_CODE_MSI;
    end else if (irq_i[1]) begin
      code_o = IRQ_CODE_MTI;
    end
    cause_o[XLEN-1] = valid_o;
    cause_o[3:0]    = code_o;
  end

endmodule

// File: rtl/rv0_trap_ctrl.sv
// rv0 machine-mode trap controller. Accepts an exception, interrupt or mret
// while idle, writes mepc/mcause/mtval/mstatus through a ready-gated CSR
// port and then issues a one-cycle PC redirect.
// Build option: define RV0_TRAP_MTVAL_EN to include the mtval write; without
// it the sequence skips mtval and exc_tval_i is ignored.
module rv0_trap_ctrl
  import rv0_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            exc_valid_i,
  input  logic [4:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic [2:0]      irq_i,
  input  logic [XLEN-1:0] irq_pc_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            req_ack_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic            csr_wready_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  localparam logic [XLEN-1:0] CLR_BIT0 = ~XLEN'(1);
  localparam logic [XLEN-1:0] CLR_BITS10 = ~XLEN'(3);

  trap_state_e state_q, state_d;

  logic            isMret_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] target_q;
`ifdef RV0_TRAP_MTVAL_EN
  logic [XLEN-1:0] tval_q;
`else
  logic unusedTval;
  assign unusedTval = ^exc_tval_i;
`endif

  logic            irqValid;
  logic [3:0]      irqCode;
  logic [XLEN-1:0] irqCause;
  logic            excTake;
  logic            irqTake;
  logic            accept;
  logic [XLEN-1:0] mtvecBase;
  logic [XLEN-1:0] acceptTarget;
  logic [XLEN-1:0] newStatus;

  rv0_irq_prio #(.XLEN(XLEN)) u_irq_prio (
    .irq_i   (irq_i),
    .valid_o (irqValid),
    .code_o  (irqCode),
    .cause_o (irqCause)
  );

  // Request arbitration while idle; reset low suppresses the accept pulse
  always_comb begin
    excTake = exc_valid_i;
    irqTake = !exc_valid_i && irqValid && mstatus_i[MSTATUS_MIE];
    accept  = rst_ni && (state_q == IDLE) && (exc_valid_i || irqTake || mret_i);
  end

  // Redirect target chosen at acceptance: vectored only for interrupts in mode 01
  always_comb begin
    mtvecBase    = mtvec_i & CLR_BITS10;
    acceptTarget = mtvecBase;
    if (excTake) begin
      acceptTarget = mtvecBase;
    end else if (irqTake) begin
      if (mtvec_i[1:0] == 2'b01) begin
        acceptTarget = mtvecBase + {{(XLEN-6){1'b0}}, irqCode, 2'b00};
      end
    end else begin
      acceptTarget = mepc_i & CLR_BIT0;
    end
  end

  // Capture all request data in the accept cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      isMret_q  <= 1'b0;
      pc_q      <= '0;
      cause_q   <= '0;
      mstatus_q <= '0;
      target_q  <= '0;
`ifdef RV0_TRAP_MTVAL_EN
      tval_q    <= '0;
`endif
    end else if (accept) begin
      isMret_q  <= !excTake && !irqTake;
      mstatus_q <= mstatus_i;
      target_q  <= acceptTarget;
      if (excTake) begin
        pc_q    <= exc_pc_i & CLR_BIT0;
        cause_q <= {{(XLEN-5){1'b0}}, exc_cause_i};
`ifdef RV0_TRAP_MTVAL_EN
        tval_q  <= exc_tval_i;
`endif
      end else if (irqTake) begin
        pc_q    <= irq_pc_i & CLR_BIT0;
        cause_q <= irqCause;
`ifdef RV0_TRAP_MTVAL_EN
        tval_q  <= '0;
`endif
      end
    end
  end

  // New mstatus value derived from the snapshot taken at acceptance
  always_comb begin
    newStatus = mstatus_q;
    if (isMret_q) begin
      newStatus[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      newStatus[MSTATUS_MPIE] = 1'b1;
    end else begin
      newStatus[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      newStatus[MSTATUS_MIE]  = 1'b0;
    end
    newStatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; CSR outputs come from latched data so they hold while stalled
  always_comb begin
    state_d          = state_q;
    req_ack_o        = 1'b0;
    busy_o           = 1'b1;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (accept) begin
          req_ack_o = 1'b1;
          state_d   = (excTake || irqTake) ? WR_MEPC : WR_MSTATUS;
        end
      end
      WR_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = pc_q;
        if (csr_wready_i) state_d = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
`ifdef RV0_TRAP_MTVAL_EN
        if (csr_wready_i) state_d = WR_MTVAL;
`else
        if (csr_wready_i) state_d = WR_MSTATUS;
`endif
      end
`ifdef RV0_TRAP_MTVAL_EN
      WR_MTVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MTVAL;
        csr_wdata_o = tval_q;
        if (csr_wready_i) state_d = WR_MSTATUS;
      end
`endif
      WR_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = newStatus;
        if (csr_wready_i) state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        state_d          = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
